// File: rtl/bpsk_link_if.sv
// Word-level handshake between the word source/sink and the BPSK link.
// The source drives in_valid/data_in, the link returns in_ready and the received word.
interface bpsk_link_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  in_valid,
    input  data_in,
    output in_ready,
    output out_valid,
    output data_out
  );

  modport master (
    output in_valid,
    output data_in,
    input  in_ready,
    input  out_valid,
    input  data_out
  );
endinterface

// File: rtl/bpsk_link.sv
// Bit-serial antipodal link: LSB-first serialiser, saturating noisy channel,
// integrate-and-dump receiver that reassembles DATA_W-bit words.
module bpsk_link #(
  parameter int DATA_W = 8,
  parameter int SAMP_W = 9,
  parameter int SPS    = 4,
  parameter int AMP    = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  bpsk_link_if.slave               link,
  input  logic signed [7:0]        noise_in,
  input  logic                     noise_en,
  output logic signed [SAMP_W-1:0] tx_sample,
  output logic                     tx_valid,
  output logic [15:0]              sat_cnt
);

  localparam int SPS_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ACC_W = SAMP_W + $clog2(SPS) + 1;

  localparam logic [SPS_W-1:0]         SPS_LAST = SPS_W'(SPS - 1);
  localparam logic [BIT_W-1:0]         BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic signed [SAMP_W-1:0] AMP_POS  = SAMP_W'(AMP);
  localparam logic signed [SAMP_W-1:0] AMP_NEG  = SAMP_W'(-AMP);
  localparam logic signed [SAMP_W-1:0] SAMP_MAX = {1'b0, {(SAMP_W-1){1'b1}}};
  localparam logic signed [SAMP_W-1:0] SAMP_MIN = {1'b1, {(SAMP_W-1){1'b0}}};

  typedef enum logic {IDLE, SEND} tx_state_t;

  function automatic logic signed [SAMP_W-1:0] symbol(input logic b);
    return b ? AMP_POS : AMP_NEG;
  endfunction

  // One guard bit above the sample width: overflow shows as guard != sign.
  function automatic logic is_clipped(input logic signed [SAMP_W:0] s);
    return s[SAMP_W] != s[SAMP_W-1];
  endfunction

  function automatic logic signed [SAMP_W-1:0] sat_sample(input logic signed [SAMP_W:0] s);
    if (is_clipped(s))
      return s[SAMP_W] ? SAMP_MIN : SAMP_MAX;
    return s[SAMP_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic decide(input logic signed [ACC_W-1:0] a);
    return ~a[ACC_W-1];
  endfunction

  tx_state_t                 state;
  logic                      in_ready_r;
  logic [DATA_W-1:0]         shreg;
  logic [DATA_W-1:0]         shreg_shift;
  logic [SPS_W-1:0]          samp_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic signed [SAMP_W-1:0]  tx_sample_p0;
  logic                      vld_p0;
  logic                      accept;
  logic                      bit_end;

  logic signed [SAMP_W:0]    ch_sum;
  logic signed [SAMP_W-1:0]  ch_p1;
  logic                      vld_p1;
  logic [15:0]               sat_cnt_r;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic [SPS_W-1:0]          rx_samp;
  logic [BIT_W-1:0]          rx_bit;
  logic                      decided;
  logic                      rx_bit_end;
  logic [DATA_W-1:0]         rx_word;
  logic [DATA_W-1:0]         word_nxt;
  logic [DATA_W-1:0]         data_out_p2;
  logic                      vld_p2;

  always_comb begin
    accept      = link.in_valid && in_ready_r;
    bit_end     = (state == SEND) && (samp_cnt == SPS_LAST);
    shreg_shift = shreg >> 1;
    ch_sum      = {tx_sample_p0[SAMP_W-1], tx_sample_p0}
                + (noise_en ? {{(SAMP_W-7){noise_in[7]}}, noise_in} : '0);
    acc_sum     = acc + {{(ACC_W-SAMP_W){ch_p1[SAMP_W-1]}}, ch_p1};
    decided     = decide(acc_sum);
    rx_bit_end  = vld_p1 && (rx_samp == SPS_LAST);
    word_nxt    = (rx_word >> 1) | (DATA_W'(decided) << (DATA_W - 1));
  end

  // Stage p0: transmit FSM, one registered sample per cycle while SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready_r   <= 1'b0;
      vld_p0       <= 1'b0;
      tx_sample_p0 <= '0;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (accept) begin
            state        <= SEND;
            in_ready_r   <= 1'b0;
            vld_p0       <= 1'b1;
            tx_sample_p0 <= symbol(link.data_in[0]);
            samp_cnt     <= '0;
            bit_cnt      <= '0;
          end
        end
        SEND: begin
          if (samp_cnt == SPS_LAST) begin
            samp_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state        <= IDLE;
              in_ready_r   <= 1'b1;
              vld_p0       <= 1'b0;
              tx_sample_p0 <= '0;
            end else begin
              bit_cnt      <= bit_cnt + 1'b1;
              tx_sample_p0 <= symbol(shreg_shift[0]);
            end
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      shreg <= link.data_in;
    else if (bit_end)
      shreg <= shreg_shift;
  end

  // Stage p1: channel adds noise and clamps to the sample range.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      sat_cnt_r <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0 && is_clipped(ch_sum))
        sat_cnt_r <= sat_inc(sat_cnt_r);
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0)
      ch_p1 <= sat_sample(ch_sum);
  end

  // Stage p2: integrate-and-dump per bit, word emitted after DATA_W decisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2      <= 1'b0;
      data_out_p2 <= '0;
      acc         <= '0;
      rx_samp     <= '0;
      rx_bit      <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        if (rx_samp == SPS_LAST) begin
          rx_samp <= '0;
          acc     <= '0;
          if (rx_bit == BIT_LAST) begin
            rx_bit      <= '0;
            data_out_p2 <= word_nxt;
            vld_p2      <= 1'b1;
          end else begin
            rx_bit <= rx_bit + 1'b1;
          end
        end else begin
          rx_samp <= rx_samp + 1'b1;
          acc     <= acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_bit_end)
      rx_word <= word_nxt;
  end

  assign link.in_ready  = in_ready_r;
  assign link.out_valid = vld_p2;
  assign link.data_out  = data_out_p2;
  assign tx_sample      = tx_sample_p0;
  assign tx_valid       = vld_p0;
  assign sat_cnt        = sat_cnt_r;

endmodule

// File: tb/tb_bpsk_link.sv
// Scoreboard bench for bpsk_link: default build, an AMP=200 build and an SPS=1 build.
module tb_bpsk_link;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_acc = 0;

  typedef struct packed {
    logic [7:0]  w;
    logic [31:0] cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   txq[$];

  bpsk_link_if #(.DATA_W(8)) if0 ();
  bpsk_link_if #(.DATA_W(8)) if1 ();
  bpsk_link_if #(.DATA_W(8)) if2 ();

  logic signed [7:0] noise0 = '0, noise1 = '0, noise2 = '0;
  logic              nen0 = 1'b0, nen1 = 1'b0, nen2 = 1'b0;
  logic signed [8:0] txs0, txs1, txs2;
  logic              txv0, txv1, txv2;
  logic [15:0]       sat0, sat1, sat2;

  bpsk_link #(.DATA_W(8), .SAMP_W(9), .SPS(4), .AMP(128)) dut0 (
    .clk(clk), .reset(rst), .link(if0.slave), .noise_in(noise0), .noise_en(nen0),
    .tx_sample(txs0), .tx_valid(txv0), .sat_cnt(sat0));
  bpsk_link #(.DATA_W(8), .SAMP_W(9), .SPS(4), .AMP(200)) dut1 (
    .clk(clk), .reset(rst), .link(if1.slave), .noise_in(noise1), .noise_en(nen1),
    .tx_sample(txs1), .tx_valid(txv1), .sat_cnt(sat1));
  bpsk_link #(.DATA_W(8), .SAMP_W(9), .SPS(1), .AMP(128)) dut2 (
    .clk(clk), .reset(rst), .link(if2.slave), .noise_in(noise2), .noise_en(nen2),
    .tx_sample(txs2), .tx_valid(txv2), .sat_cnt(sat2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected output at cycle %0d, expected none", name, cyc + 1);
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] w);
    case (d)
      0: begin if0.in_valid = v; if0.data_in = w; end
      1: begin if1.in_valid = v; if1.data_in = w; end
      default: begin if2.in_valid = v; if2.data_in = w; end
    endcase
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0: return if0.in_ready;
      1: return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  // Called at posedge+1; returns one cycle after the accepting edge.
  task automatic send(input int d, input logic [7:0] w, input bit hold);
    int   nsps;
    bit   ok;
    exp_t e;
    nsps = (d == 2) ? 1 : 4;
    drive(d, 1'b1, w);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (rdy(d)) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("accept", int'(ok), 1);
    if (!ok) begin
      drive(d, 1'b0, w);
      return;
    end
    last_acc = cyc + 1;
    e.w   = w;
    e.cyc = last_acc + 8 * nsps + 2;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    if (d == 0)
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 4; j++)
          txq.push_back(w[k] ? 128 : -128);
    @(posedge clk); #1;
    if (!hold) drive(d, 1'b0, w);
  endtask

  task automatic drain(input string name);
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 400; t++) begin
      empty = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && (txq.size() == 0);
      if (empty) break;
      @(posedge clk); #1;
    end
    check(name, int'(empty), 1);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst) begin
      if (if0.out_valid) begin
        if (q0.size() == 0) unexpected("d0 out_valid");
        else begin
          e = q0.pop_front();
          check("d0 data_out", if0.data_out, e.w);
          check("d0 out cycle", cyc + 1, e.cyc);
        end
      end
      if (txv0) begin
        if (txq.size() == 0) unexpected("d0 tx_valid");
        else check("d0 tx_sample", txs0, txq.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && if1.out_valid) begin
      if (q1.size() == 0) unexpected("d1 out_valid");
      else begin
        e = q1.pop_front();
        check("d1 data_out", if1.data_out, e.w);
        check("d1 out cycle", cyc + 1, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && if2.out_valid) begin
      if (q2.size() == 0) unexpected("d2 out_valid");
      else begin
        e = q2.pop_front();
        check("d2 data_out", if2.data_out, e.w);
        check("d2 out cycle", cyc + 1, e.cyc);
      end
    end
  end

  initial begin : stim
    int a1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst in_ready", if0.in_ready, 0);
    check("rst tx_valid", txv0, 0);
    check("rst tx_sample", txs0, 0);
    check("rst out_valid", if0.out_valid, 0);
    check("rst data_out", if0.data_out, 0);
    check("rst sat_cnt", sat0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", if0.in_ready, 1);

    send(0, 8'hAA, 1'b0);
    drain("drain 0xAA");
    check("sat_cnt clean", sat0, 0);

    nen0 = 1'b1; noise0 = 8'sd127;
    send(0, 8'h00, 1'b0);
    drain("drain noisy 0x00");
    noise0 = -8'sd128;
    send(0, 8'hFF, 1'b0);
    drain("drain tie 0xFF");
    check("sat_cnt noisy", sat0, 0);

    nen0 = 1'b0; noise0 = 8'sd0;
    send(0, 8'h66, 1'b1);
    a1 = last_acc;
    send(0, 8'h3F, 1'b0);
    check("back-to-back gap", last_acc - a1, 33);
    drain("drain back-to-back");

    send(0, 8'h55, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    q0.delete();
    txq.delete();
    @(posedge clk); #1;
    check("abort in_ready", if0.in_ready, 0);
    check("abort tx_valid", txv0, 0);
    check("abort tx_sample", txs0, 0);
    check("abort out_valid", if0.out_valid, 0);
    check("abort data_out", if0.data_out, 0);
    check("abort sat_cnt", sat0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort in_ready after", if0.in_ready, 1);

    noise0 = -8'sd128; nen0 = 1'b0;
    send(0, 8'h5A, 1'b0);
    drain("drain 0x5A");
    check("sat_cnt masked noise", sat0, 0);

    nen1 = 1'b1; noise1 = 8'sd127;
    send(1, 8'h0F, 1'b0);
    drain("drain amp200");
    check("sat_cnt amp200", sat1, 16);

    send(2, 8'hC3, 1'b0);
    drain("drain sps1");
    check("sat_cnt sps1", sat2, 0);

    repeat (40) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
